// File: rtl/cdc_pulse_rate_bridge_if.sv
// cdc_pulse_rate_bridge_if: event inputs, overflow clears and slow-domain outputs of the pulse bridge
interface cdc_pulse_rate_bridge_if #(
    parameter int NCH = 4
) ();
    logic [NCH-1:0] fast_in;
    logic [NCH-1:0] ovf_clr_i;
    logic           slow_ce_o;
    logic [NCH-1:0] slow_out;
    logic [NCH-1:0] pending_o;
    logic [NCH-1:0] ovf_o;
    modport master (
        output fast_in, ovf_clr_i,
        input  slow_ce_o, slow_out, pending_o, ovf_o
    );
    modport slave (
        input  fast_in, ovf_clr_i,
        output slow_ce_o, slow_out, pending_o, ovf_o
    );
endinterface

// File: rtl/cdc_pulse_rate_bridge.sv
// cdc_pulse_rate_bridge: lossless multi-channel pulse transfer into a 1-in-DIV clock-enable domain
module cdc_pulse_rate_bridge #(
    parameter int NCH   = 4,
    parameter int CNT_W = 4,
    parameter int DIV   = 8,
    parameter int EDGE  = 0
) (
    input logic clk,
    input logic reset_i,
    cdc_pulse_rate_bridge_if.slave bus
);
    localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
    logic [CW-1:0]    ce_cnt;
    logic             slow_ce, ce_last;
    logic [NCH-1:0]   fast_d, ev, nz, full, dec, drop, slow_out, ovf;
    logic [CNT_W-1:0] cnt     [NCH];
    logic [CNT_W-1:0] cnt_nxt [NCH];
    assign ce_last = ce_cnt == CW'(DIV - 1);
    assign ev = EDGE != 0 ? bus.fast_in & ~fast_d : bus.fast_in;
    // a simultaneous event and delivery cancel out, so saturation never drops in that case
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            nz[i]      = cnt[i] != '0;
            full[i]    = &cnt[i];
            dec[i]     = nz[i] & slow_ce;
            drop[i]    = ev[i] & ~dec[i] & full[i];
            cnt_nxt[i] = ev[i] & ~dec[i] & ~full[i] ? cnt[i] + 1'b1 :
                         ~ev[i] & dec[i] ? cnt[i] - 1'b1 : cnt[i];
        end
    end
    always_ff @(posedge clk) begin
        if (reset_i) begin
            ce_cnt   <= '0;
            slow_ce  <= 1'b0;
            fast_d   <= '0;
            slow_out <= '0;
            ovf      <= '0;
            for (int i = 0; i < NCH; i++) cnt[i] <= '0;
        end else begin
            ce_cnt  <= ce_last ? '0 : ce_cnt + 1'b1;
            slow_ce <= ce_last;
            fast_d  <= bus.fast_in;
            cnt     <= cnt_nxt;
            ovf     <= drop | (ovf & ~bus.ovf_clr_i);
            if (slow_ce) slow_out <= nz;
        end
    end
    assign bus.slow_ce_o = slow_ce;
    assign bus.slow_out  = slow_out;
    assign bus.pending_o = nz;
    assign bus.ovf_o     = ovf;
endmodule

// File: tb/tb_cdc_pulse_rate_bridge.sv
// tb_cdc_pulse_rate_bridge: directed checks of the pulse bridge with NCH=2, CNT_W=3, DIV=4 (EDGE 0 and 1)
module tb_cdc_pulse_rate_bridge;
    logic clk = 1'b0;
    logic reset_i;
    int total = 0;
    int bad = 0;
    int hi [3];
    int rise [3];
    logic [2:0] prv = '0;
    always #5 clk = ~clk;
    cdc_pulse_rate_bridge_if #(.NCH(2)) b0 ();
    cdc_pulse_rate_bridge_if #(.NCH(2)) b1 ();
    cdc_pulse_rate_bridge #(.NCH(2), .CNT_W(3), .DIV(4), .EDGE(0)) u0 (
        .clk(clk), .reset_i(reset_i), .bus(b0)
    );
    cdc_pulse_rate_bridge #(.NCH(2), .CNT_W(3), .DIV(4), .EDGE(1)) u1 (
        .clk(clk), .reset_i(reset_i), .bus(b1)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    // every step lands on a falling edge and tallies slow_out activity for u0 ch0/ch1 and u1 ch0
    task automatic tick();
        logic [2:0] s;
        @(negedge clk);
        s = {b1.slow_out[0], b0.slow_out[1], b0.slow_out[0]};
        for (int i = 0; i < 3; i++) begin
            if (s[i] === 1'b1) hi[i]++;
            if (s[i] === 1'b1 && prv[i] === 1'b0) rise[i]++;
        end
        prv = s;
    endtask
    task automatic clr_mon();
        for (int i = 0; i < 3; i++) begin
            hi[i] = 0;
            rise[i] = 0;
        end
    endtask
    task automatic wait_ce();
        int n = 0;
        tick();
        while (b0.slow_ce_o !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        chk("wait_ce", b0.slow_ce_o, 1);
    endtask
    initial begin
        int k;
        reset_i = 1'b1;
        b0.fast_in = '0;
        b0.ovf_clr_i = '0;
        b1.fast_in = '0;
        b1.ovf_clr_i = '0;
        clr_mon();
        tick();
        chk("rst_ce", b0.slow_ce_o, 0);
        chk("rst_out", b0.slow_out, 0);
        chk("rst_pend", b0.pending_o, 0);
        chk("rst_ovf", b0.ovf_o, 0);
        reset_i = 1'b0;
        repeat (3) tick();
        chk("ce_before_div", b0.slow_ce_o, 0);
        tick();
        chk("ce_first", b0.slow_ce_o, 1);
        tick();
        chk("ce_one_cycle", b0.slow_ce_o, 0);
        // single pulse on ch0
        wait_ce();
        tick();
        b0.fast_in = 2'b01;
        tick();
        b0.fast_in = 2'b00;
        chk("t1_pend", b0.pending_o, 2'b01);
        chk("t1_out_early", b0.slow_out, 0);
        repeat (2) tick();
        chk("t1_ce", b0.slow_ce_o, 1);
        chk("t1_out_pre", b0.slow_out, 0);
        clr_mon();
        tick();
        chk("t1_out_start", b0.slow_out, 2'b01);
        chk("t1_pend_clr", b0.pending_o, 0);
        repeat (11) tick();
        chk("t1_hi0", hi[0], 4);
        chk("t1_hi1", hi[1], 0);
        chk("t1_ovf", b0.ovf_o, 0);
        // event landing on a ce edge with empty counter waits a full slow period
        wait_ce();
        b0.fast_in = 2'b01;
        tick();
        b0.fast_in = 2'b00;
        chk("ce_ev_out", b0.slow_out[0], 0);
        chk("ce_ev_pend", b0.pending_o[0], 1);
        repeat (3) tick();
        chk("ce_ev_still_lo", b0.slow_out[0], 0);
        tick();
        chk("ce_ev_hi", b0.slow_out[0], 1);
        repeat (8) tick();
        chk("ce_ev_done", b0.slow_out[0], 0);
        // 5 back-to-back events
        wait_ce();
        clr_mon();
        tick();
        b0.fast_in = 2'b01;
        repeat (5) tick();
        b0.fast_in = 2'b00;
        repeat (30) tick();
        chk("t2_hi", hi[0], 20);
        chk("t2_rise", rise[0], 1);
        chk("t2_ovf", b0.ovf_o[0], 0);
        chk("t2_pend", b0.pending_o, 0);
        // saturation: 12 events, 2 dropped
        wait_ce();
        clr_mon();
        tick();
        b0.fast_in = 2'b01;
        repeat (12) tick();
        b0.fast_in = 2'b00;
        chk("t3_ovf_set", b0.ovf_o, 2'b01);
        chk("t3_pend", b0.pending_o[0], 1);
        repeat (40) tick();
        chk("t3_hi", hi[0], 40);
        chk("t3_rise", rise[0], 1);
        chk("t3_ovf_sticky", b0.ovf_o[0], 1);
        b0.ovf_clr_i = 2'b01;
        tick();
        b0.ovf_clr_i = 2'b00;
        chk("t3_ovf_clr", b0.ovf_o, 0);
        // simultaneous pulses on both channels
        wait_ce();
        clr_mon();
        tick();
        b0.fast_in = 2'b11;
        tick();
        b0.fast_in = 2'b00;
        repeat (3) tick();
        chk("t4_both", b0.slow_out, 2'b11);
        repeat (11) tick();
        chk("t4_hi0", hi[0], 4);
        chk("t4_hi1", hi[1], 4);
        chk("t4_rise1", rise[1], 1);
        // rising-edge mode: long high input is one event
        wait_ce();
        clr_mon();
        tick();
        b1.fast_in = 2'b01;
        repeat (10) tick();
        b1.fast_in = 2'b00;
        repeat (20) tick();
        chk("t5_hi", hi[2], 4);
        chk("t5_rise", rise[2], 1);
        chk("t5_ovf", b1.ovf_o, 0);
        // reset while counter holds 3 and slow_out is high
        wait_ce();
        tick();
        b0.fast_in = 2'b01;
        repeat (4) tick();
        b0.fast_in = 2'b00;
        chk("t6_pre_pend", b0.pending_o[0], 1);
        chk("t6_pre_out", b0.slow_out[0], 1);
        reset_i = 1'b1;
        tick();
        chk("t6_out", b0.slow_out, 0);
        chk("t6_pend", b0.pending_o, 0);
        chk("t6_ovf", b0.ovf_o, 0);
        chk("t6_ce", b0.slow_ce_o, 0);
        reset_i = 1'b0;
        clr_mon();
        k = 0;
        do begin
            tick();
            k++;
        end while (b0.slow_ce_o !== 1'b1 && k < 10);
        chk("t6_first_ce", k, 4);
        repeat (20) tick();
        chk("t6_no_out", hi[0], 0);
        chk("t6_pend_end", b0.pending_o, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
